neuron_mac_param: RTL

- Parametrised successor to the layer-1 fixed-point neuron.
- Accumulates N_INPUTS signed value×weight products onto a loaded bias, in a wide accumulator.
- Saturates the result to DATA_W and applies a selectable activation (linear / ReLU / leaky ReLU).
- Presents the result on a valid/ready output. Sits between the weight/input sequencer and the next layer's input buffer.

---
 rtl/neuron_pkg.sv | 18 +
 rtl/neuron_act_sat.sv | 37 +++
 rtl/neuron_mac_param.sv | 128 ++++++++++++
 3 files changed

// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared constants and state encoding for the layer neurons
package neuron_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_FRAC_W = 16;

  localparam int ACT_LINEAR = 0;
  localparam int ACT_RELU   = 1;
  localparam int ACT_LEAKY  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_RESULT = 2'd3
  } state_e;

endpackage

// File: rtl/neuron_act_sat.sv
// rtl/neuron_act_sat.sv - wide accumulator to DATA_W saturation followed by activation
module neuron_act_sat
  import neuron_pkg::*;
#(
  parameter int ACC_W      = 64,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int ACT_MODE   = ACT_RELU,
  parameter int LEAK_SHIFT = 3
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [DATA_W-1:0] result_o,
  output logic                     sat_o
);

  logic [ACC_W-DATA_W:0]    top_bits;
  logic signed [DATA_W-1:0] sat_val;

  // The value fits in DATA_W only when every bit above the result sign bit matches it.
  always_comb begin
    top_bits = acc_i[ACC_W-1:DATA_W-1];
    sat_o    = !((&top_bits) || !(|top_bits));
    if (sat_o) begin
      sat_val = acc_i[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      sat_val = acc_i[DATA_W-1:0];
    end
    result_o = sat_val;
    if (sat_val[DATA_W-1]) begin
      if (ACT_MODE == ACT_RELU) begin
        result_o = '0;
      end else if (ACT_MODE == ACT_LEAKY) begin
        result_o = sat_val >>> LEAK_SHIFT;
      end
    end
  end

endmodule

// File: rtl/neuron_mac_param.sv
// rtl/neuron_mac_param.sv - parametrised fixed-point neuron: bias + sum of value*weight, saturate, activate
module neuron_mac_param
  import neuron_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FRAC_W     = DEFAULT_FRAC_W,
  parameter int N_INPUTS   = 784,
  parameter int ACT_MODE   = ACT_RELU,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     bias_load,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] value,
  input  logic signed [DATA_W-1:0] weight,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     sat_flag,
  output logic                     busy
);

  localparam int ACC_W = 2*DATA_W - FRAC_W + $clog2(N_INPUTS+1);
  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS-1);

  state_e                     state_q, state_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [2*DATA_W-1:0] prod_q, prod_full, prod_shift;
  logic                       p_vld_q;
  logic [CNT_W-1:0]           cnt_q;
  logic signed [DATA_W-1:0]   out_data_q, act_result;
  logic                       sat_q, act_sat;
  logic                       accept, start, last_accept;

  assign in_ready    = (state_q == ST_ACCUM);
  assign out_valid   = (state_q == ST_RESULT);
  assign busy        = (state_q != ST_IDLE);
  assign out_data    = out_data_q;
  assign sat_flag    = sat_q;
  assign accept      = in_valid & in_ready;
  assign start       = (state_q == ST_IDLE) & bias_load;
  assign last_accept = accept & (cnt_q == CNT_LAST);
  assign prod_full   = value * weight;
  assign prod_shift  = prod_q >>> FRAC_W;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (bias_load)   state_d = ST_ACCUM;
        ST_ACCUM:  if (last_accept) state_d = ST_DRAIN;
        ST_DRAIN:                   state_d = ST_RESULT;
        ST_RESULT: if (out_ready)   state_d = ST_IDLE;
        default:                    state_d = ST_IDLE;
      endcase
    end
  end

  // The result register is loaded from acc_d so the final product is included on RESULT entry.
  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (start) begin
      acc_d = ACC_W'(value);
    end else if (p_vld_q) begin
      acc_d = acc_q + ACC_W'(prod_shift);
    end
  end

  neuron_act_sat #(
    .ACC_W      (ACC_W),
    .DATA_W     (DATA_W),
    .ACT_MODE   (ACT_MODE),
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_act_sat (
    .acc_i    (acc_d),
    .result_o (act_result),
    .sat_o    (act_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      prod_q     <= '0;
      p_vld_q    <= 1'b0;
      cnt_q      <= '0;
      out_data_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (clear) begin
        p_vld_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        p_vld_q <= accept;
        if (accept) begin
          prod_q <= prod_full;
        end
        // Holding at the last index keeps the counter from wrapping when N_INPUTS is a power of two.
        if (start) begin
          cnt_q <= '0;
        end else if (accept && !last_accept) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
        if (state_q == ST_DRAIN) begin
          out_data_q <= act_result;
          sat_q      <= act_sat;
        end
      end
    end
  end

endmodule
